// File: rtl/adder_chk_pkg.sv
// Shared types and defaults for the adder response checker.
// The state encoding is exported so checkers can bind to the debug state output.
package adder_chk_pkg;

    localparam int DEFAULT_WIDTH   = 64;
    localparam int DEFAULT_COUNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A new run may only be armed when no run is in progress.
    function automatic logic can_arm(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/golden_add.sv
// Reference adder: combinational a + b + c_in, returned as {carry, sum}.
module golden_add #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH:0]   result_o
);

    assign result_o = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/adder_response_checker.sv
// Response checker: accepts adder result tuples, recomputes the golden sum in a
// second pipeline stage, counts checks/errors and captures the first mismatch.
module adder_response_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] expected_count,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               c_in,
    input  logic [WIDTH-1:0]   sum,
    input  logic               c_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [COUNT_W-1:0] chk_count,
    output logic [COUNT_W-1:0] err_count,
    output logic               first_err_valid,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b,
    output logic               first_err_cin,
    output logic [WIDTH-1:0]   first_err_sum,
    output logic               first_err_cout,
    output logic [1:0]         dbg_state
);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + COUNT_W'(1);
    endfunction

    state_t state_q, state_d;

    logic [COUNT_W-1:0] exp_q, acc_q, chk_q, err_q;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_sum_q;
    logic             s1_cin_q, s1_cout_q;

    logic             fe_valid_q;
    logic [WIDTH-1:0] fe_a_q, fe_b_q, fe_sum_q;
    logic             fe_cin_q, fe_cout_q;

    logic             arm, accept, last_check, mismatch;
    logic [WIDTH:0]   golden;

    // Handshake: a tuple transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on registered state, never on in_valid.
    assign arm        = start && can_arm(state_q);
    assign accept     = in_valid && in_ready;
    assign last_check = s1_valid_q && (acc_q == exp_q);

    golden_add #(.WIDTH(WIDTH)) u_golden (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .cin_i    (s1_cin_q),
        .result_o (golden)
    );

    assign mismatch = (golden != {s1_cout_q, s1_sum_q});

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = (expected_count == '0) ? ST_DONE : ST_RUN;
            ST_RUN:           if (last_check) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_RUN) && (acc_q < exp_q);
        busy      = (state_q == ST_RUN);
        done      = (state_q == ST_DONE);
        pass      = (state_q == ST_DONE) && (err_q == '0);
        dbg_state = state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q      <= '0;
            acc_q      <= '0;
            chk_q      <= '0;
            err_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sum_q   <= '0;
            s1_cin_q   <= 1'b0;
            s1_cout_q  <= 1'b0;
            fe_valid_q <= 1'b0;
            fe_a_q     <= '0;
            fe_b_q     <= '0;
            fe_sum_q   <= '0;
            fe_cin_q   <= 1'b0;
            fe_cout_q  <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q    <= a;
                s1_b_q    <= b;
                s1_cin_q  <= c_in;
                s1_sum_q  <= sum;
                s1_cout_q <= c_out;
            end
            if (arm) begin
                exp_q      <= expected_count;
                acc_q      <= '0;
                chk_q      <= '0;
                err_q      <= '0;
                fe_valid_q <= 1'b0;
                fe_a_q     <= '0;
                fe_b_q     <= '0;
                fe_sum_q   <= '0;
                fe_cin_q   <= 1'b0;
                fe_cout_q  <= 1'b0;
            end else begin
                if (accept) acc_q <= sat_inc(acc_q);
                if (s1_valid_q) begin
                    chk_q <= sat_inc(chk_q);
                    if (mismatch) begin
                        err_q <= sat_inc(err_q);
                        // Only the first mismatch of a run is kept.
                        if (!fe_valid_q) begin
                            fe_valid_q <= 1'b1;
                            fe_a_q     <= s1_a_q;
                            fe_b_q     <= s1_b_q;
                            fe_cin_q   <= s1_cin_q;
                            fe_sum_q   <= s1_sum_q;
                            fe_cout_q  <= s1_cout_q;
                        end
                    end
                end
            end
        end
    end

    assign chk_count       = chk_q;
    assign err_count       = err_q;
    assign first_err_valid = fe_valid_q;
    assign first_err_a     = fe_a_q;
    assign first_err_b     = fe_b_q;
    assign first_err_cin   = fe_cin_q;
    assign first_err_sum   = fe_sum_q;
    assign first_err_cout  = fe_cout_q;

endmodule

// File: tb/tb_adder_response_checker.sv
// Directed bench for adder_response_checker with a queue-based error-count scoreboard.
module tb_adder_response_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] expected_count;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a, b, sum;
    logic        c_in, c_out;
    logic        busy, done, pass;
    logic [31:0] chk_count, err_count;
    logic        first_err_valid;
    logic [63:0] first_err_a, first_err_b, first_err_sum;
    logic        first_err_cin, first_err_cout;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_err;
    logic [31:0] chk_prev = 0;

    adder_response_checker #(.WIDTH(64), .COUNT_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .expected_count  (expected_count),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a               (a),
        .b               (b),
        .c_in            (c_in),
        .sum             (sum),
        .c_out           (c_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .chk_count       (chk_count),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_a     (first_err_a),
        .first_err_b     (first_err_b),
        .first_err_cin   (first_err_cin),
        .first_err_sum   (first_err_sum),
        .first_err_cout  (first_err_cout),
        .dbg_state       (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [64:0] gold(input logic [63:0] x, input logic [63:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {64'd0, ci};
    endfunction

    // driver tasks: all begin and end 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [63:0] pa, input logic [63:0] pb, input logic pci,
                        input logic [63:0] psum, input logic pcout);
        int  waited;
        logic got;
        waited = 0;
        got    = 1'b0;
        a = pa; b = pb; c_in = pci; sum = psum; c_out = pcout;
        in_valid = 1'b1;
        while (!got && waited < 50) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                if ({pcout, psum} != gold(pa, pb, pci)) exp_err = exp_err + 1;
                exp_q.push_back(exp_err);
            end else begin
                waited++;
            end
            tick();
        end
        if (!got) check("accept_timeout", 64'(waited), 64'd0);
    endtask

    task automatic start_run(input logic [31:0] n);
        in_valid       = 1'b0;
        start          = 1'b1;
        expected_count = n;
        tick();
        start   = 1'b0;
        exp_err = 0;
        exp_q.delete();
        check("start_busy", busy, (n != 0));
        check("start_done", done, (n == 0));
        check("start_chk_cleared", chk_count, 0);
        check("start_err_cleared", err_count, 0);
        check("start_fe_cleared", first_err_valid, 0);
    endtask

    task automatic end_run(input logic [31:0] n, input logic [31:0] e, input logic p);
        in_valid = 1'b0;
        check("last_in_ready_low", in_ready, 0);
        check("done_not_early", done, 0);
        tick();
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_pass", pass, p);
        check("end_chk_count", chk_count, n);
        check("end_err_count", err_count, e);
    endtask

    // scoreboard monitor: pops one expected err_count per completed check
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (chk_count == chk_prev + 32'd1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: check %0d appeared with no expected entry", chk_count);
            end else begin
                exp_v = exp_q.pop_front();
                check("sb_err_count", err_count, exp_v);
            end
        end
        chk_prev = chk_count;
    end

    logic [63:0] ones;
    logic [63:0] va, vb, fa, fb, fs;
    logic        vc, fc, fco;
    logic [64:0] g;

    initial begin
        ones = '1;
        rst_n = 1'b0; start = 1'b0; expected_count = 0; in_valid = 1'b0;
        a = 0; b = 0; sum = 0; c_in = 0; c_out = 0; exp_err = 0;
        fa = 0; fb = 0; fs = 0; fc = 0; fco = 0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_chk", chk_count, 0);
        check("rst_err", err_count, 0);
        check("rst_fe_valid", first_err_valid, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        tick();

        // 16 correct samples, back to back: a=i, b=2i, c_in=i[0], sum=3i+i[0]
        start_run(16);
        for (int i = 0; i < 16; i++) begin
            va = 64'(i);
            send(va, 2 * va, va[0], 3 * va + {63'd0, va[0]}, 1'b0);
        end
        end_run(16, 0, 1);
        check("run16_fe_valid", first_err_valid, 0);
        idle(2);

        // 10 samples, sum corrupted on samples 3 and 7
        start_run(10);
        for (int i = 0; i < 10; i++) begin
            va = 64'hFEDC_BA98_7654_3210 + 64'(i) * 64'h0101_0101;
            vb = 64'h0123_4567_89AB_CDEF * 64'(i + 1);
            vc = i[0];
            g  = gold(va, vb, vc);
            if (i == 3 || i == 7) begin
                if (i == 3) begin
                    fa = va; fb = vb; fc = vc; fs = g[63:0] ^ 64'd1; fco = g[64];
                end
                send(va, vb, vc, g[63:0] ^ 64'd1, g[64]);
            end else begin
                send(va, vb, vc, g[63:0], g[64]);
            end
        end
        end_run(10, 2, 0);
        check("fault_fe_valid", first_err_valid, 1);
        check("fault_fe_a", first_err_a, fa);
        check("fault_fe_b", first_err_b, fb);
        check("fault_fe_cin", first_err_cin, fc);
        check("fault_fe_sum", first_err_sum, fs);
        check("fault_fe_cout", first_err_cout, fco);
        idle(2);

        // carry boundary: all-ones + 0 + 1 = {1, 0}
        start_run(2);
        send(ones, 64'd0, 1'b1, 64'd0, 1'b1);
        send(ones, 64'd0, 1'b1, 64'd0, 1'b0);
        end_run(2, 1, 0);
        check("carry_fe_a", first_err_a, ones);
        check("carry_fe_sum", first_err_sum, 0);
        check("carry_fe_cout", first_err_cout, 0);
        idle(2);

        // random in_valid gaps, then in_valid held high past the limit
        start_run(5);
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            va = 64'(100 + i);
            send(va, va, 1'b1, 2 * va + 64'd1, 1'b0);
        end
        check("hs_ready_drop", in_ready, 0);
        tick();
        check("hs_done", done, 1);
        check("hs_pass", pass, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hs_ready_stays_low", in_ready, 0);
        end
        check("hs_chk_count", chk_count, 5);
        idle(2);

        // start pulsed mid-run is ignored
        start_run(6);
        for (int i = 0; i < 3; i++) send(64'(i), 64'(7), 1'b0, 64'(i + 7), 1'b0);
        in_valid       = 1'b0;
        start          = 1'b1;
        expected_count = 2;
        tick();
        start = 1'b0;
        check("midstart_busy", busy, 1);
        check("midstart_chk", chk_count, 3);
        for (int i = 3; i < 6; i++) send(64'(i), 64'(7), 1'b0, 64'(i + 7), 1'b0);
        end_run(6, 0, 1);
        idle(2);

        // expected_count of zero completes immediately
        start_run(0);
        check("zero_pass", pass, 1);
        check("zero_in_ready", in_ready, 0);
        idle(2);

        // reset during sample 3 of 8 aborts the run
        start_run(8);
        for (int i = 0; i < 3; i++) send(64'(i), 64'(1), 1'b0, 64'(i + 1), 1'b0);
        a = 64'd3; b = 64'd1; c_in = 1'b0; sum = 64'd4; c_out = 1'b0;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        tick();
        exp_q.delete();
        check("abort_in_ready", in_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pass", pass, 0);
        check("abort_chk", chk_count, 0);
        check("abort_err", err_count, 0);
        check("abort_state", dbg_state, 0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(3);
        check("abort_s1_discarded", chk_count, 0);
        check("abort_idle_ready", in_ready, 0);
        check("sb_drained", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_response_checker.md
# adder_response_checker

Self-checking response monitor for the adder verification flow: the receiving end of the operand/result stream that the stimulus benches drive into `verificationRCA64`-class adders. It accepts (a, b, c_in, sum, c_out) tuples over a valid/ready handshake and recomputes the golden result. It counts checks and mismatches, captures the first failing tuple, and reports pass/fail once an expected number of samples has been checked. It sits beside the DUT adder, fed by the stimulus generator and the DUT outputs.

## Interface
- `WIDTH`, 64: operand/sum width.
- `COUNT_W`, 32: width of the expected, check and error counters.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset. One clock; reset is synchronous and active-low.
- `start`  in  1: one-cycle pulse; arms a run. Honoured only in IDLE or DONE.
- `expected_count`  in  COUNT_W: number of samples in the run; sampled on `start`.
- `in_valid`  in  1: tuple present.
- `in_ready`  out  1: checker accepts the tuple this cycle.
- `a`, `b`  in  WIDTH: operands.
- `c_in`  in  1: carry in.
- `sum`  in  WIDTH: DUT sum.
- `c_out`  in  1: DUT carry out.
- `busy`  out  1: state is RUN.
- `done`  out  1: level; state is DONE.
- `pass`  out  1: `done` and `err_count == 0`.
- `chk_count`, `err_count`  out  COUNT_W: samples checked and mismatches.
- `first_err_valid`  out  1: a mismatch has been captured.
- `first_err_a`, `first_err_b`  out  WIDTH; `first_err_cin`  out  1: operands of the first mismatch.
- `first_err_sum`  out  WIDTH; `first_err_cout`  out  1: DUT result of the first mismatch.

## Operation
- FSM states: IDLE → RUN → DONE → (on `start`) RUN.
  - IDLE + `start`: clear all counters and capture registers, latch `expected_count`, go to RUN. If `expected_count` is 0, go directly to DONE with `pass`=1.
  - RUN: `in_ready` = (accepted < expected). A tuple is accepted when `in_valid && in_ready`.
  - `start` in RUN is ignored.
  - DONE + `start`: same behaviour as from IDLE.
- Golden result: the (WIDTH+1)-bit value {c_out_exp, sum_exp} = a + b + c_in, zero-extended. A mismatch is any bit difference in either sum or carry.
- Pipeline:
  - Stage 1 registers the accepted tuple and its valid flag.
  - Stage 2 compares, increments `chk_count`, increments `err_count` on a mismatch, and loads the first-error registers if `first_err_valid` is 0.
- Counters saturate at all-ones and never wrap. The internal accepted counter is COUNT_W bits wide.
- First-error registers are loaded once per run; later mismatches do not overwrite them.

## Timing
- Reset values: state IDLE; `in_ready`, `busy`, `done`, `pass`, `first_err_valid` = 0; all counters and capture registers = 0.
- Reset asserted mid-run aborts the run. All outputs return to their reset values at that edge, and an in-flight stage-1 sample is discarded.
- Accept at edge k → `chk_count`/`err_count`/first-error registers reflect the sample after edge k+1.
- Last accepted sample at edge k:
  - `in_ready` drops in the cycle after edge k.
  - State enters DONE at edge k+1, together with the final counter update.
  - `done`/`pass` are valid from edge k+1.
- Back-to-back accepts run at one sample per cycle. `in_valid` low stalls without penalty.
- `start` at edge j: `busy` is high after edge j. Counters read 0 after edge j.

## Structure
- Shared package `adder_chk_pkg`: state enum (IDLE, RUN, DONE) and default WIDTH/COUNT_W constants.
- One sub-module, `golden_add`: combinational WIDTH-bit a+b+c_in returning {carry, sum}. It is instantiated in stage 2.
- Everything else (FSM, pipeline register, counters, capture) lives in the top.

## Test plan
- Correct DUT, WIDTH=64, `expected_count`=16, tuples a=i, b=2i, c_in=i[0], continuous `in_valid` → `done` after the 16th accept +1 cycle; `chk_count`=16, `err_count`=0, `pass`=1.
- Injected faults: DUT sum forced to golden^1 on samples 3 and 7 of 10 → `err_count`=2, `pass`=0. The first-error registers hold sample 3's a/b/c_in and its corrupted sum.
- Carry boundary: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1, DUT sum=0, c_out=1 → no error. The same tuple with c_out=0 → `err_count`=1.
- Handshake and limits:
  - `in_valid` toggled 1-0-1 randomly with `expected_count`=5: exactly 5 accepts, then `in_ready` stays 0 with `in_valid` still high.
  - `expected_count`=0: `done`=1 and `pass`=1 one cycle after `start`.
- Control during a run:
  - `rst_n` low at sample 3 of 8: all outputs 0 next edge.
  - A new `start` in DONE clears the counters.
  - `start` pulsed mid-RUN is ignored (`chk_count` continues).
